fifo_param_sync: RTL and testbench
==================================

Name: fifo_param_sync

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. It is generalised in width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count and a synchronous flush. It has two read modes: standard (registered read) and first-word-fall-through (FWFT). It is a drop-in buffer between producer and consumer blocks in the same clock domain, and is verified with the existing class-based transaction/coverage/scoreboard flow.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, need not be a power of two)
ALMOST_FULL_TH, FIFO_DEPTH-1, almostfull asserts when count >= this value (1..FIFO_DEPTH)
ALMOST_EMPTY_TH, 1, almostempty asserts when count <= this value (0..FIFO_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  synchronous clear of contents, no reset of data_out
wr_en  in  1  write request
data_in  in  FIFO_WIDTH  write data
rd_en  in  1  read request (FWFT: pop/acknowledge head)
data_out  out  FIFO_WIDTH  read data
rd_valid  out  1  data_out holds valid read data
wr_ack  out  1  registered pulse: previous-cycle write accepted
overflow  out  1  registered pulse: previous-cycle write rejected
underflow  out  1  registered pulse: previous-cycle read rejected
full  out  1  count == FIFO_DEPTH (combinational from count)
empty  out  1  count == 0
almostfull  out  1  count >= ALMOST_FULL_TH
almostempty  out  1  count <= ALMOST_EMPTY_TH
count  out  CNT_W  occupancy, CNT_W = $clog2(FIFO_DEPTH+1)

Behaviour:
- Priority each edge: rst_n low > flush > read/write.
- Reset (rst_n=0 at edge): wr_ptr, rd_ptr and count go to 0. data_out, rd_valid, wr_ack, overflow and underflow go to 0. Flags follow count: empty=1, almostempty=1, full=0, almostfull=0. A reset mid-burst discards all contents; memory array contents are not cleared.
- flush=1: pointers and count go to 0; wr_ack, overflow and underflow go to 0; rd_valid goes to 0; data_out holds its value; wr_en/rd_en that cycle are ignored.
- Read accepted (rd_acc) = rd_en && count!=0.
- Write accepted (wr_acc) = wr_en && (count!=FIFO_DEPTH || rd_acc). A write while full is accepted only alongside an accepted read.
- Simultaneous read and write when empty: the write is accepted and the read is rejected (underflow=1 next cycle), in both modes.
- Simultaneous accepted read and write: count is unchanged.
- Otherwise count increments on wr_acc alone and decrements on rd_acc alone.
- Pointers advance on accept and wrap from FIFO_DEPTH-1 to 0 (explicit compare, not modulo by power of two).
- wr_ack <= wr_acc; overflow <= wr_en && !wr_acc; underflow <= rd_en && !rd_acc. Each is a one-cycle pulse.
- Standard mode: on rd_acc, data_out <= mem[rd_ptr] with 1-cycle latency. rd_valid <= rd_acc. data_out holds its value when no read occurs.
- FWFT mode: data_out = mem[rd_ptr] combinationally; rd_valid = !empty. rd_en pops the head. A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Flags are combinational from the registered count; there are no glitch paths from wr_en/rd_en.
- Elaboration-time checks ($error) if FIFO_DEPTH < 2 or a threshold is out of range.

Decomposition:
- shared_pkg: default FIFO_WIDTH/FIFO_DEPTH constants; typedef enum logic {STD_READ, FWFT_READ} fifo_mode_e; the test_finished flag (already present).
- Sub-module fifo_ram_sdp: FIFO_WIDTH x FIFO_DEPTH simple dual-port array with one synchronous write port and one asynchronous read port. The top level registers the read output in standard mode.

Test Plan:
- Reset then idle (DEPTH=8, FWFT=0): empty=1, almostempty=1, count=0, full=0, all pulses 0, data_out=0.
- Write 0x0001..0x0008 back-to-back: wr_ack high 8 cycles; almostfull at count=7; full at count=8. A 9th write gives overflow=1 and wr_ack=0, with count held at 8.
- While full, assert wr_en=rd_en with data_in=0xAAAA: read returns 0x0001 next cycle, wr_ack=1, overflow=0, count stays 8. Draining then yields 0x0002..0x0008 followed by 0xAAAA.
- Empty FIFO, wr_en=rd_en=1 with 0x1234: underflow=1, wr_ack=1, count=1. Next cycle a read returns 0x1234 with rd_valid=1.
- FWFT=1: write 0x00C3 into an empty FIFO. data_out=0x00C3 and rd_valid=1 in the next cycle with no rd_en. After a pop, empty=1 and rd_valid=0.
- Fill to 5, then flush=1 with wr_en=1: count=0, empty=1, no wr_ack, data_out unchanged. Also drive rst_n=0 mid-burst: all state returns to reset values on the next edge.

Source files
------------

// File: rtl/fifo_param_sync_pkg.sv
// Shared defaults and types for the parametrised synchronous FIFO.
package fifo_param_sync_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    typedef enum logic {
        STD_READ  = 1'b0,
        FWFT_READ = 1'b1
    } fifo_mode_e;

    // Raised by a bench once its stimulus is complete
    bit test_finished;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram_sdp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are never cleared, not even by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_sync.sv
// Single-clock FIFO with programmable thresholds, occupancy count, flush and
// selectable standard (registered) or first-word-fall-through read.
module fifo_param_sync
    import fifo_param_sync_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH      = DEF_FIFO_WIDTH,
    parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_TH = 1,
    parameter int unsigned FWFT            = 0,
    parameter int unsigned CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam fifo_mode_e  MODE  = (FWFT != 0) ? FWFT_READ : STD_READ;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY_TH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    if (FIFO_WIDTH < 1) begin : g_chk_width
        $error("fifo_param_sync: FIFO_WIDTH must be at least 1");
    end
    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("fifo_param_sync: FIFO_DEPTH must be at least 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_chk_af
        $error("fifo_param_sync: ALMOST_FULL_TH out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("fifo_param_sync: ALMOST_EMPTY_TH out of range 0..FIFO_DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ram_we;
    logic [FIFO_WIDTH-1:0] ram_rdata;

    // Flags come only from the registered count, never from the request inputs
    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign almostfull  = (count >= CNT_AF);
    assign almostempty = (count <= CNT_AE);

    // A write into a full FIFO is allowed only when a read frees a slot the same edge
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign ram_we = rst_n && !flush && wr_acc;

    fifo_ram_sdp #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointers, occupancy and handshake pulses; reset beats flush beats traffic
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

    if (MODE == FWFT_READ) begin : g_fwft
        // Head of the queue is always visible; rd_en only pops it
        assign data_out = ram_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] data_reg;
        logic                  valid_reg;

        // Registered read: capture the head on an accepted read, hold otherwise
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (flush) begin
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= rd_acc;
                if (rd_acc) begin
                    data_reg <= ram_rdata;
                end
            end
        end

        assign data_out = data_reg;
        assign rd_valid = valid_reg;
    end

endmodule

// File: tb/tb_fifo_param_sync.sv
// Bench for fifo_param_sync: a standard-read and an FWFT instance share all
// inputs and are checked against a queue model, directed vectors and random traffic.
module tb_fifo_param_sync;
    import fifo_param_sync_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0]  s_data_out, f_data_out;
    logic          s_rd_valid, f_rd_valid;
    logic          s_wr_ack, f_wr_ack;
    logic          s_overflow, f_overflow;
    logic          s_underflow, f_underflow;
    logic          s_full, f_full;
    logic          s_empty, f_empty;
    logic          s_almostfull, f_almostfull;
    logic          s_almostempty, f_almostempty;
    logic [CW-1:0] s_count, f_count;

    always #5 clk = ~clk;

    fifo_param_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_data_out), .rd_valid(s_rd_valid), .wr_ack(s_wr_ack),
        .overflow(s_overflow), .underflow(s_underflow), .full(s_full), .empty(s_empty),
        .almostfull(s_almostfull), .almostempty(s_almostempty), .count(s_count)
    );

    fifo_param_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .wr_ack(f_wr_ack),
        .overflow(f_overflow), .underflow(f_underflow), .full(f_full), .empty(f_empty),
        .almostfull(f_almostfull), .almostempty(f_almostempty), .count(f_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a plain queue plus the registered pulses/standard read word
    logic [W-1:0] q[$];
    logic         m_ack = 1'b0, m_ov = 1'b0, m_un = 1'b0, m_valid = 1'b0;
    logic [W-1:0] m_data = '0;

    typedef struct {
        logic         r, f, w, rd;
        logic [W-1:0] din;
        int           cnt;
        logic         ack, ov, un, val;
        logic [W-1:0] data;
        logic         fval;
        logic [W-1:0] fdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  n;
        bit  racc, wacc;
        n = q.size();
        if (!rst_n) begin
            q.delete();
            m_ack = 0; m_ov = 0; m_un = 0; m_valid = 0; m_data = '0;
        end else if (flush) begin
            q.delete();
            m_ack = 0; m_ov = 0; m_un = 0; m_valid = 0;
        end else begin
            racc = rd_en && (n != 0);
            wacc = wr_en && ((n != D) || racc);
            if (racc) m_data = q.pop_front();
            if (wacc) q.push_back(data_in);
            m_valid = racc;
            m_ack   = wacc;
            m_ov    = wr_en && !wacc;
            m_un    = rd_en && !racc;
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, " s_count"}, 32'(s_count), 32'(n));
        chk({tag, " f_count"}, 32'(f_count), 32'(n));
        chk({tag, " s_empty"}, 32'(s_empty), 32'(n == 0));
        chk({tag, " s_full"}, 32'(s_full), 32'(n == D));
        chk({tag, " s_afull"}, 32'(s_almostfull), 32'(n >= AF));
        chk({tag, " s_aempty"}, 32'(s_almostempty), 32'(n <= AE));
        chk({tag, " f_flags"}, {28'd0, f_empty, f_full, f_almostfull, f_almostempty},
            {28'd0, n == 0, n == D, n >= AF, n <= AE});
        chk({tag, " s_pulses"}, {29'd0, s_wr_ack, s_overflow, s_underflow},
            {29'd0, m_ack, m_ov, m_un});
        chk({tag, " f_pulses"}, {29'd0, f_wr_ack, f_overflow, f_underflow},
            {29'd0, m_ack, m_ov, m_un});
        chk({tag, " s_rd_valid"}, 32'(s_rd_valid), 32'(m_valid));
        chk({tag, " s_data_out"}, 32'(s_data_out), 32'(m_data));
        chk({tag, " f_rd_valid"}, 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) chk({tag, " f_data_out"}, 32'(f_data_out), 32'(q[0]));
    endtask

    task automatic step(input logic r, input logic f, input logic w, input logic rd,
                        input logic [W-1:0] d, input string tag);
        rst_n = r; flush = f; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    function automatic void add(logic r, logic f, logic w, logic rd, logic [W-1:0] din,
                                int cnt, logic ack, logic ov, logic un, logic val,
                                logic [W-1:0] data, logic fval, logic [W-1:0] fdata);
        vec_t v;
        v.r = r; v.f = f; v.w = w; v.rd = rd; v.din = din; v.cnt = cnt;
        v.ack = ack; v.ov = ov; v.un = un; v.val = val; v.data = data;
        v.fval = fval; v.fdata = fdata;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset, then fill 1..8, overflow, write-through-read while full
        add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        for (int i = 1; i <= 8; i++)
            add(1, 0, 1, 0, W'(i), i, 1, 0, 0, 0, 16'h0000, 1, 16'h0001);
        add(1, 0, 1, 0, 16'h0009, 8, 0, 1, 0, 0, 16'h0000, 1, 16'h0001);
        add(1, 0, 1, 1, 16'hAAAA, 8, 1, 0, 0, 1, 16'h0001, 1, 16'h0002);
        // Drain 0x0002..0x0008 then 0xAAAA, then read while empty
        for (int i = 0; i < 7; i++)
            add(1, 0, 0, 1, 16'h0000, 7 - i, 0, 0, 0, 1, W'(2 + i),
                1, (i < 6) ? W'(3 + i) : 16'hAAAA);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'hAAAA, 0, 16'h0000);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'hAAAA, 0, 16'h0000);
        // Simultaneous read/write on empty: write wins, read underflows
        add(1, 0, 1, 1, 16'h1234, 1, 1, 0, 1, 0, 16'hAAAA, 1, 16'h1234);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'h1234, 0, 16'h0000);
        // Fill to 5 then flush with a write in the same cycle
        for (int i = 1; i <= 5; i++)
            add(1, 0, 1, 0, W'(16'h0050 + i), i, 1, 0, 0, 0, 16'h1234, 1, 16'h0051);
        add(1, 1, 1, 0, 16'h0056, 0, 0, 0, 0, 0, 16'h1234, 0, 16'h0000);
        // Refill, read, then reset mid-burst
        for (int i = 1; i <= 3; i++)
            add(1, 0, 1, 0, W'(16'h0060 + i), i, 1, 0, 0, 0, 16'h1234, 1, 16'h0061);
        add(1, 0, 0, 1, 16'h0000, 2, 0, 0, 0, 1, 16'h0061, 1, 16'h0062);
        add(0, 0, 1, 1, 16'h0077, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        // FWFT: word shows up without rd_en, pop empties it
        add(1, 0, 1, 0, 16'h00C3, 1, 1, 0, 0, 0, 16'h0000, 1, 16'h00C3);
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h00C3);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'h00C3, 0, 16'h0000);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].r, vecs[i].f, vecs[i].w, vecs[i].rd, vecs[i].din, tag);
            chk({tag, " count"}, 32'(s_count), 32'(vecs[i].cnt));
            chk({tag, " ack/ov/un"}, {29'd0, s_wr_ack, s_overflow, s_underflow},
                {29'd0, vecs[i].ack, vecs[i].ov, vecs[i].un});
            chk({tag, " rd_valid"}, 32'(s_rd_valid), 32'(vecs[i].val));
            chk({tag, " data_out"}, 32'(s_data_out), 32'(vecs[i].data));
            chk({tag, " fwft rd_valid"}, 32'(f_rd_valid), 32'(vecs[i].fval));
            if (vecs[i].fval) chk({tag, " fwft data_out"}, 32'(f_data_out), 32'(vecs[i].fdata));
        end

        // Random traffic, biased so the FIFO visits both full and empty
        for (int i = 0; i < 3000; i++) begin
            logic r, f, w, rd;
            int   phase;
            phase = (i / 200) % 2;
            r  = ($urandom_range(0, 299) != 0);
            f  = ($urandom_range(0, 79) == 0);
            w  = ($urandom_range(0, 99) < (phase ? 30 : 75));
            rd = ($urandom_range(0, 99) < (phase ? 75 : 30));
            step(r, f, w, rd, W'($urandom), $sformatf("rnd%0d", i));
        end

        test_finished = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
